// File: rtl/switch_event_ctrl.sv
// Push-switch front end: synchronise, debounce on pulse_en, arbitrate presses
// into a small code FIFO that the processor pops through a memory-mapped read.
module switch_event_ctrl #(
    parameter int NUM_SW     = 3,
    parameter int DEB_TICKS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              pulse_en,
    input  logic              rd_en,
    input  logic [31:0]       addr,
    input  logic [NUM_SW-1:0] switches,
    output logic [31:0]       rd_data,
    output logic              irq,
    output logic              overflow
);

    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEB_LIMIT = 4'(DEB_TICKS);
    localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

    logic [NUM_SW-1:0] sync1_r;
    logic [NUM_SW-1:0] sync2_r;
    logic [NUM_SW-1:0] deb_r;
    logic [3:0]        cnt_r [NUM_SW];
    logic [NUM_SW-1:0] pending_r;
    logic [2:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [4:0]        count_r;
    logic              overflow_r;
    logic              irq_r;

    logic [NUM_SW-1:0] deb_next_s;
    logic [3:0]        cnt_next_s [NUM_SW];
    logic [NUM_SW-1:0] rise_s;
    logic [NUM_SW-1:0] grant_mask_s;
    logic [NUM_SW-1:0] pending_next_s;
    logic [2:0]        grant_idx_s;
    logic              grant_valid_s;
    logic [2:0]        grant_code_s;
    logic              sel_ok_s;
    logic              data_sel_s;
    logic              status_sel_s;
    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              ovf_set_s;
    logic              overflow_next_s;
    logic [4:0]        count_next_s;
    logic [31:0]       rd_data_s;
    logic              addr_unused_s;

    assign addr_unused_s = ^{addr[31:24], addr[22:3]};

    assign sel_ok_s     = rd_en & addr[23];
    assign data_sel_s   = sel_ok_s & (addr[2:0] == 3'b001);
    assign status_sel_s = sel_ok_s & (addr[2:0] == 3'b010);
    assign empty_s      = (count_r == 5'd0);
    assign full_s       = (count_r == DEPTH_CNT);
    assign pop_s        = data_sel_s & ~empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_s       = grant_valid_s & (~full_s | pop_s);
    assign grant_code_s = grant_idx_s + 3'd1;
    assign ovf_set_s    = |(rise_s & pending_r);

    // Per-switch debounce counter and debounced level, advanced only on pulse_en.
    always_comb begin
        for (int i = 0; i < NUM_SW; i++) begin
            cnt_next_s[i] = cnt_r[i];
            deb_next_s[i] = deb_r[i];
            rise_s[i]     = 1'b0;
            if (pulse_en) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if ((cnt_r[i] + 4'd1) == DEB_LIMIT) begin
                        cnt_next_s[i] = 4'd0;
                        deb_next_s[i] = ~deb_r[i];
                        rise_s[i]     = ~deb_r[i];
                    end else begin
                        cnt_next_s[i] = cnt_r[i] + 4'd1;
                    end
                end else begin
                    cnt_next_s[i] = 4'd0;
                end
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end
    end

    // Lowest-index pending switch wins the single push slot.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 3'd0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (pending_r[i]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 3'(i);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Pending bits: clear the granted one, latch new presses unless already pending.
    always_comb begin
        grant_mask_s = '0;
        if (push_s) begin
            grant_mask_s[grant_idx_s] = 1'b1;
        end else begin
            grant_mask_s = '0;
        end
        pending_next_s = (pending_r & ~grant_mask_s) | (rise_s & ~pending_r);
    end

    // Occupancy count and sticky overflow next-state.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 5'd1;
            2'b01:   count_next_s = count_r - 5'd1;
            default: count_next_s = count_r;
        endcase
        if (ovf_set_s) begin
            overflow_next_s = 1'b1;
        end else if (status_sel_s) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Combinational read-data mux for the DATA and STATUS registers.
    always_comb begin
        if (data_sel_s) begin
            if (empty_s) begin
                rd_data_s = 32'h0;
            end else begin
                rd_data_s = {29'h0, fifo_mem_r[rd_ptr_r]};
            end
        end else if (status_sel_s) begin
            rd_data_s = {24'h0, overflow_r, full_s, empty_s, count_r};
        end else begin
            rd_data_s = 32'h0;
        end
    end

    // Synchroniser, debounce, pending and overflow state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_r    <= '0;
            sync2_r    <= '0;
            deb_r      <= '0;
            pending_r  <= '0;
            overflow_r <= 1'b0;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_r[i] <= 4'd0;
            end
        end else begin
            sync1_r    <= switches;
            sync2_r    <= sync1_r;
            deb_r      <= deb_next_s;
            pending_r  <= pending_next_s;
            overflow_r <= overflow_next_s;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    // Event FIFO storage, pointers, count and interrupt.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 5'd0;
            irq_r    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 3'd0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= grant_code_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            irq_r   <= (count_next_s != 5'd0);
        end
    end

    assign rd_data  = rd_data_s;
    assign irq      = irq_r;
    assign overflow = overflow_r;

endmodule
